prog_loader: RTL and testbench

Program loader that fills the CPU's 7x17 instruction RAM through its write port (`wr`/`wrd`/`we`) from a byte stream, then releases the CPU by raising `pc_en`. It sits between an external byte source (host link, test bench) and the `cpu` top level. It replaces manual user driving of the RAM write port and `pc_en`. CPU execution is gated off for the whole load.

---
 rtl/prog_loader_pkg.sv | 36 +++
 rtl/prog_loader_word_asm.sv | 44 ++++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and field positions for the program loader.
// Optional checksum stage is enabled by PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int WORD_W  = 17;
    localparam int ADDR_W  = 3;
    localparam int BYTE_W  = 8;

    localparam int B16_POS = 16;
    localparam int HI_LSB  = 8;
    localparam int LO_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        RX_B0,
        RX_B1,
        RX_B2,
        WRITE,
        CHECK,
        RUN
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic              b0_lsb,
        input logic [BYTE_W-1:0] b1,
        input logic [BYTE_W-1:0] b2
    );
        logic [WORD_W-1:0] w;
        w                   = '0;
        w[B16_POS]          = b0_lsb;
        w[HI_LSB +: BYTE_W] = b1;
        w[LO_LSB +: BYTE_W] = b2;
        return w;
    endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-to-word assembly and running XOR of data bytes (PROG_LOADER_CHECKSUM_EN).
// The word output merges the two latched bytes with the live third byte.
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [1:0]        idx,
    input  logic [BYTE_W-1:0] byte_in,
`ifdef PROG_LOADER_CHECKSUM_EN
    output logic [BYTE_W-1:0] csum,
`endif
    output logic [WORD_W-1:0] word
);

    logic              b0_lsb;
    logic [BYTE_W-1:0] b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_lsb <= 1'b0;
            b1     <= '0;
        end else if (clr) begin
            b0_lsb <= 1'b0;
            b1     <= '0;
        end else if (ld) begin
            if (idx == 2'd0) b0_lsb <= byte_in[0];
            if (idx == 2'd1) b1     <= byte_in;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      csum <= '0;
        else if (clr) csum <= '0;
        else if (ld)  csum <= csum ^ byte_in;
    end
`endif

    assign word = pack_word(b0_lsb, b1, byte_in);

endmodule

// File: rtl/prog_loader.sv
// Loads WORDS 17-bit words from a byte stream into the CPU instruction RAM, then raises pc_en.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before RUN.
//
// state | meaning
// IDLE  | waiting for start; CPU held off
// RX_B0 | waiting for byte0 (bit 16 in its LSB)
// RX_B1 | waiting for byte1 (bits 15:8)
// RX_B2 | waiting for byte2 (bits 7:0)
// WRITE | single-cycle RAM write of the assembled word
// CHECK | waiting for the checksum byte
// RUN   | CPU released
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WORDS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr,
    output logic [WORD_W-1:0] wrd,
    output logic              we,
    output logic              pc_en,
    output logic              busy,
    output logic              err
);

    state_t            state, nxt;
    logic [ADDR_W-1:0] addr;
    logic              acc;
    logic              last;
    logic              data_ld;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] asm_word;

    assign acc      = in_valid & in_ready;
    assign last     = (addr == ADDR_W'(WORDS - 1));
    assign data_ld  = acc && (state inside {RX_B0, RX_B1, RX_B2});
    assign byte_idx = (state == RX_B0) ? 2'd0 : (state == RX_B1) ? 2'd1 : 2'd2;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic              csum_ok;
    localparam state_t LAST_NEXT = CHECK;
    assign csum_ok = (in_data == csum);
`else
    localparam state_t LAST_NEXT = RUN;
`endif

    loader_word_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .ld      (data_ld),
        .idx     (byte_idx),
        .byte_in (in_data),
`ifdef PROG_LOADER_CHECKSUM_EN
        .csum    (csum),
`endif
        .word    (asm_word)
    );

    // start wins from every state; a WRITE in flight still finishes because we is already registered
    always_comb begin
        nxt = state;
        if (start) begin
            nxt = RX_B0;
        end else begin
            case (state)
                RX_B0: if (acc) nxt = RX_B1;
                RX_B1: if (acc) nxt = RX_B2;
                RX_B2: if (acc) nxt = WRITE;
                WRITE: nxt = last ? LAST_NEXT : RX_B0;
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: if (acc) nxt = csum_ok ? RUN : IDLE;
`endif
                default: nxt = state;
            endcase
        end
    end

    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            in_ready <= 1'b0;
            wr       <= '0;
            wrd      <= '0;
            we       <= 1'b0;
            pc_en    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt inside {RX_B0, RX_B1, RX_B2, CHECK});
            busy     <= (nxt != IDLE) && (nxt != RUN);
            pc_en    <= (nxt == RUN);
            we       <= (nxt == WRITE);
            if (nxt == WRITE) begin
                wr  <= addr;
                wrd <= asm_word;
            end
            if (start)
                addr <= '0;
            else if (state == WRITE && !last)
                addr <= addr + 1'b1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (start)
            err <= 1'b0;
        else if (state == CHECK && acc && !csum_ok)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected RAM writes come from a byte-level model queue.
// Checksum cases run only when PROG_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int NW = 7;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int LOAD_CYC = 4 * NW + 1;
`else
    localparam int LOAD_CYC = 4 * NW;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [2:0]  wr;
    logic [16:0] wrd;
    logic        we;
    logic        pc_en;
    logic        busy;
    logic        err;

    prog_loader #(.WORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr       (wr),
        .wrd      (wrd),
        .we       (we),
        .pc_en    (pc_en),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  a;
        logic [16:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] ld_bytes [3*NW];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         start_cyc   = 0;
    int         rise_cyc    = -1;
    logic       we_prev     = 1'b0;
    logic       pc_prev     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] make_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
        return {b0[0], b1, b2};
    endfunction

    // Every cycle: each we pulse must match the next expected write; RUN excludes loading.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (we) begin
                chk("we_single_cycle", {31'd0, we_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {29'd0, wr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {29'd0, wr}, {29'd0, e.a});
                    chk("write_data", {15'd0, wrd}, {15'd0, e.d});
                end
            end
            chk("run_excludes_load", {30'd0, pc_en & busy, pc_en & in_ready}, 32'd0);
            if (pc_en && !pc_prev) rise_cyc = cyc;
        end
        we_prev = we;
        pc_prev = pc_en;
    end

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc + 1;
        rise_cyc  = -1;
        @(negedge clk);
        start     = 1'b0;
        chk("after_start_pc_en", {31'd0, pc_en}, 32'd0);
        chk("after_start_busy", {31'd0, busy}, 32'd1);
        chk("after_start_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_start_err", {31'd0, err}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge just after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        if (stall) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("settle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_load(input bit stall, input logic [7:0] cs_flip, input bit exp_run);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < NW; i++)
            exp_q.push_back({3'(i), make_word(ld_bytes[3*i], ld_bytes[3*i+1], ld_bytes[3*i+2])});
        for (int i = 0; i < 3 * NW; i++) cs ^= ld_bytes[i];
        pulse_start();
        for (int i = 0; i < 3 * NW; i++) send_byte(ld_bytes[i], stall);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(cs ^ cs_flip, stall);
`endif
        in_valid = 1'b0;
        settle();
        @(negedge clk);
        chk("writes_pending", exp_q.size(), 32'd0);
        chk("end_pc_en", {31'd0, pc_en}, {31'd0, exp_run});
        chk("end_err", {31'd0, err}, {31'd0, !exp_run});
        chk("end_in_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr", {29'd0, wr}, 32'd0);
        chk("rst_wrd", {15'd0, wrd}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // model pins
        chk("pin_bit16_word", {15'd0, make_word(8'hFF, 8'hA5, 8'h3C)}, 32'h0001_A53C);
        for (int i = 0; i < NW; i++) begin
            ld_bytes[3*i]   = 8'h00;
            ld_bytes[3*i+1] = 8'h00;
            ld_bytes[3*i+2] = 8'(i + 1);
        end
        cs0 = 8'h00;
        for (int i = 0; i < 3 * NW; i++) cs0 ^= ld_bytes[i];
        chk("pin_xor_1_to_7", {24'd0, cs0}, 32'd0);

        // reset while in RX_B1: everything back to reset values, no write
        pulse_start();
        send_byte(8'h12, 1'b0);
        in_data = 8'h34;
        rst     = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_wr", {29'd0, wr}, 32'd0);
        chk("midrst_wrd", {15'd0, wrd}, 32'd0);
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // nominal: words 1..7 back-to-back
        do_load(1'b0, 8'h00, 1'b1);
        chk("load_latency", rise_cyc - start_cyc, LOAD_CYC);
        chk("nominal_last_wr", {29'd0, wr}, 32'd6);
        chk("nominal_last_wrd", {15'd0, wrd}, 32'h0000_0007);

        // stalled source, restart from RUN, last word exercises bit-16 mapping
        for (int i = 0; i < NW; i++) begin
            ld_bytes[3*i]   = 8'(8'h80 | (i & 1));
            ld_bytes[3*i+1] = 8'(8'h11 * i);
            ld_bytes[3*i+2] = 8'(8'hF0 - i);
        end
        ld_bytes[3*NW-3] = 8'hFF;
        ld_bytes[3*NW-2] = 8'hA5;
        ld_bytes[3*NW-1] = 8'h3C;
        do_load(1'b1, 8'h00, 1'b1);
        chk("stall_latency_stretched", {31'd0, (rise_cyc - start_cyc) > LOAD_CYC}, 32'd1);
        chk("bit16_wr_hold", {29'd0, wr}, 32'd6);
        chk("bit16_wrd_hold", {15'd0, wrd}, 32'h0001_A53C);

`ifdef PROG_LOADER_CHECKSUM_EN
        // wrong checksum byte: err set, CPU stays off, loader back in IDLE
        do_load(1'b0, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        chk("bad_cs_err_sticky", {31'd0, err}, 32'd1);
        chk("bad_cs_pc_en", {31'd0, pc_en}, 32'd0);
        chk("bad_cs_idle", {30'd0, busy, in_ready}, 32'd0);
`endif

        // reload with fresh data (clears err when checksum is enabled)
        for (int i = 0; i < NW; i++) begin
            ld_bytes[3*i]   = 8'(i);
            ld_bytes[3*i+1] = 8'(8'hC3 ^ i);
            ld_bytes[3*i+2] = 8'(8'h5A + i);
        end
        do_load(1'b0, 8'h00, 1'b1);
        chk("reload_latency", rise_cyc - start_cyc, LOAD_CYC);
        chk("reload_last_wrd", {15'd0, wrd}, 32'h0000_C560);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
